pwm_multi_decoder: RTL
======================

// Module: pwm_multi_decoder
// PURPOSE
//  Multi-channel PWM audio input decoder; successor to the single-channel decoder.
//  Each channel measures true high time and true period per PWM cycle.
//  A shared iterative divider converts high/period into a signed sample (exact duty, no period-shift approximation).
//  Output is a single channel-tagged valid/ready stream feeding the audio mixer / FM modulator front end.
// PARAMETERS
//  NUM_CH       4            number of PWM input channels (1..8)
//  CLK_FREQ_HZ  100_000_000  system clock frequency
//  PWM_FREQ_HZ  50_000       nominal PWM frequency; MAX_COUNT = CLK_FREQ_HZ/PWM_FREQ_HZ
//  SAMPLE_BITS  16           output sample width, signed
//  TIMEOUT_MUL  2            DC timeout = TIMEOUT_MUL*MAX_COUNT cycles without a rising edge
// PORTS
//  clk           in   1            system clock
//  rst           in   1            async reset, active high
//  enable        in   NUM_CH       per-channel enable
//  pwm_in        in   NUM_CH       raw async PWM inputs
//  sample_out    out  SAMPLE_BITS  signed decoded sample
//  sample_ch     out  clog2(NUM_CH) (min 1)  channel index of sample_out
//  sample_valid  out  1            sample_out/sample_ch valid
//  sample_ready  in   1            downstream accepts when valid&ready
//  overrun       out  NUM_CH       sticky: capture overwrote an unconverted capture
//  busy          out  1            divider active or any capture pending
// BEHAVIOUR
//  Interface: one clock (clk); reset (rst) is asynchronous and active-high.
//  Reset: all outputs 0; all counters 0; pending 0; measuring 0; divider IDLE.
//  Per-channel front end:
//   - 2-flop synchroniser plus a third flop for edge detection.
//   - Counters saturate at TIMEOUT = TIMEOUT_MUL*MAX_COUNT.
//  Rising edge, channel enabled:
//   - If measuring: latch (high, period) into the channel capture slot and set pending.
//   - Always: restart counters and set measuring.
//  Timeout (period counter = TIMEOUT), measuring=1:
//   - Latch level high: (high=1, period=1). Level low: (high=0, period=1).
//   - Set pending; clear measuring. Exactly one DC sample per timeout.
//  Capture while pending=1: overwrite the slot and set overrun[ch].
//   - overrun[ch] clears only while enable[ch]=0.
//  enable[ch]=0: clear counters, measuring, pending; no new captures.
//  Arbiter (divider IDLE, any pending): round-robin from last served channel + 1.
//   - Copy that slot to the divider, clear pending, enter DIV.
//   - A capture in the same cycle as its pending-clear is kept (pending stays 1), no overrun.
//  Divider FSM:
//   - IDLE -> DIV: restoring division of (high << SAMPLE_BITS) by period.
//   - DIV runs exactly SAMPLE_BITS+1 cycles, producing a SAMPLE_BITS+1-bit quotient, then -> OUT.
//   - OUT: saturate quotient to 2^SAMPLE_BITS-1, subtract 2^(SAMPLE_BITS-1).
//     Result: 0% duty = -2^(SB-1); 50% = 0; 100% = 2^(SB-1)-1.
//   - OUT: assert sample_valid. Hold sample_out/sample_ch stable until sample_ready; then -> IDLE.
//  Latency: capture at cycle t, divider idle, ready=1 -> sample_valid at t+SAMPLE_BITS+3.
//  Backpressure: the divider stalls in OUT; channel slots keep capturing; overruns are flagged, never dropped silently.
//  period=0 cannot occur (minimum 1); the divider still guards it, forcing the result to max positive.
//  busy = (state!=IDLE) | (|pending).
// TESTING
//  T1 1 ch, 50 kHz, 25% duty (500/2000) -> sample_out=-16384 +/-1, sample_ch=0, one valid per period.
//  T2 ch2 at 48 kHz / 75% duty, ch0 at 50% duty -> exact +16384 and 0 (true period used), tags correct.
//  T3 hold pwm_in[1]=1 past 4000 cycles -> exactly one sample +32767; held 0 -> exactly one -32768.
//  T4 all 4 ch edge on the same cycle -> 4 samples in order 0,1,2,3 (after reset), no overrun.
//  T5 sample_ready=0 for 3 PWM periods -> sample held stable, overrun[ch] set; deassert enable -> cleared.
//  T6 assert rst mid-division -> all outputs 0 next cycle; after release, first sample only after a full new period.

Source files
------------

// File: rtl/pwm_multi_decoder.sv
// Multi-channel PWM audio decoder: per-channel high/period capture, round-robin
// arbitration into one shared restoring divider, channel-tagged sample stream.
module pwm_multi_decoder #(
  parameter int NUM_CH      = 4,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int PWM_FREQ_HZ = 50_000,
  parameter int SAMPLE_BITS = 16,
  parameter int TIMEOUT_MUL = 2,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      enable,
  input  logic [NUM_CH-1:0]      pwm_in,
  output logic [SAMPLE_BITS-1:0] sample_out,
  output logic [CH_W-1:0]        sample_ch,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic [NUM_CH-1:0]      overrun,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam int MAX_COUNT = CLK_FREQ_HZ / PWM_FREQ_HZ;
  localparam int TIMEOUT   = TIMEOUT_MUL * MAX_COUNT;
  localparam int CW        = $clog2(TIMEOUT + 1);
  localparam int QW        = SAMPLE_BITS + 1;
  localparam int RW        = CW + 1;
  localparam int SW        = $clog2(QW);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t TMO_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_OUT} state_t;

  logic [NUM_CH-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_CH-1:0] meas_q, pend_q, ovr_q;
  cnt_t              high_cnt_q [NUM_CH];
  cnt_t              per_cnt_q  [NUM_CH];
  cnt_t              slot_high_q[NUM_CH];
  cnt_t              slot_per_q [NUM_CH];

  logic [NUM_CH-1:0] rise, tmo, cap, grant;
  logic              gnt_found, gnt_valid;
  logic [CH_W-1:0]   gnt_idx, cand;

  state_t            state_q;
  logic [CH_W-1:0]   last_q, ch_q;
  cnt_t              divisor_q;
  logic [RW-1:0]     rem_q;
  logic [QW-1:0]     quo_q;
  logic [SW-1:0]     step_q;
  logic [SAMPLE_BITS-1:0] out_q;
  logic [CH_W-1:0]   out_ch_q;
  logic              valid_q;

  logic              ge;
  logic [RW-1:0]     rem_sub;
  logic [SAMPLE_BITS-1:0] q_sat;

  // Round-robin search starting one past the channel served last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(last_q) + i) % NUM_CH);
      if (!gnt_found && pend_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign gnt_valid = (state_q == S_IDLE) && gnt_found;

  always_comb begin
    rise  = '0;
    tmo   = '0;
    cap   = '0;
    grant = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rise[c]  = sync2_q[c] & ~sync3_q[c];
      tmo[c]   = meas_q[c] & (per_cnt_q[c] == TMO_C);
      cap[c]   = enable[c] & meas_q[c] & (rise[c] | tmo[c]);
      grant[c] = gnt_valid & (gnt_idx == CH_W'(c));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      meas_q  <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        high_cnt_q[c]  <= '0;
        per_cnt_q[c]   <= '0;
        slot_high_q[c] <= '0;
        slot_per_q[c]  <= '0;
      end
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      for (int c = 0; c < NUM_CH; c++) begin
        if (!enable[c]) begin
          high_cnt_q[c] <= '0;
          per_cnt_q[c]  <= '0;
          meas_q[c]     <= 1'b0;
          pend_q[c]     <= 1'b0;
          ovr_q[c]      <= 1'b0;
        end else begin
          // A capture coinciding with this channel's grant survives as a fresh pending slot.
          if (cap[c]) begin
            slot_high_q[c] <= rise[c] ? high_cnt_q[c] : CW'(sync2_q[c]);
            slot_per_q[c]  <= rise[c] ? per_cnt_q[c] : CW'(1);
            pend_q[c]      <= 1'b1;
            if (pend_q[c] && !grant[c]) ovr_q[c] <= 1'b1;
          end else if (grant[c]) begin
            pend_q[c] <= 1'b0;
          end
          if (rise[c]) begin
            high_cnt_q[c] <= CW'(1);
            per_cnt_q[c]  <= CW'(1);
            meas_q[c]     <= 1'b1;
          end else begin
            if (tmo[c]) meas_q[c] <= 1'b0;
            if (per_cnt_q[c] != TMO_C) per_cnt_q[c] <= per_cnt_q[c] + CW'(1);
            if (sync2_q[c] && high_cnt_q[c] != TMO_C) high_cnt_q[c] <= high_cnt_q[c] + CW'(1);
          end
        end
      end
    end
  end

  assign ge      = rem_q >= {1'b0, divisor_q};
  assign rem_sub = rem_q - {1'b0, divisor_q};
  assign q_sat   = (quo_q[QW-1] || divisor_q == '0) ? '1 : quo_q[SAMPLE_BITS-1:0];

  // Stream: a sample is transferred on a cycle with sample_valid & sample_ready;
  // while valid and not ready, sample_out/sample_ch are held unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= CH_W'(NUM_CH - 1);
      ch_q      <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      step_q    <= '0;
      out_q     <= '0;
      out_ch_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            ch_q      <= gnt_idx;
            last_q    <= gnt_idx;
            divisor_q <= slot_per_q[gnt_idx];
            rem_q     <= {1'b0, slot_high_q[gnt_idx]};
            quo_q     <= '0;
            step_q    <= '0;
            state_q   <= S_DIV;
          end
        end
        S_DIV: begin
          rem_q  <= ge ? {rem_sub[RW-2:0], 1'b0} : {rem_q[RW-2:0], 1'b0};
          quo_q  <= {quo_q[QW-2:0], ge};
          step_q <= step_q + SW'(1);
          if (step_q == SW'(QW - 1)) state_q <= S_OUT;
        end
        S_OUT: begin
          // Offset binary to two's complement is an MSB flip.
          if (!valid_q) begin
            out_q    <= {~q_sat[SAMPLE_BITS-1], q_sat[SAMPLE_BITS-2:0]};
            out_ch_q <= ch_q;
            valid_q  <= 1'b1;
          end else if (sample_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sample_out   = out_q;
  assign sample_ch    = out_ch_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q != S_IDLE) || (|pend_q);
  assign dbg_state    = state_q;

endmodule
